// File: rtl/tdm_pkg.sv
// Shared types and sizing for the TDM receive path.
// Optional build macro: TDM_PARITY_EN adds a parity slot per frame.
package tdm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

`ifdef TDM_PARITY_EN
    localparam int NUM_SLOTS  = 5;
    localparam int SLOT_IDX_W = 3;
`else
    localparam int NUM_SLOTS  = 4;
    localparam int SLOT_IDX_W = 2;
`endif

    localparam logic [SLOT_IDX_W-1:0] LAST_SLOT =
        SLOT_IDX_W'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_demultiplexer_if.sv
// Frame output bundle: four channels plus a valid/ready handshake.
// The demultiplexer drives the master side, the consumer the slave side.
interface tdm_demultiplexer_if #(
    parameter int DATA_W = 1
);
    logic [DATA_W-1:0] out0;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out2;
    logic [DATA_W-1:0] out3;
    logic              frame_valid;
    logic              frame_ready;

    modport master (
        output out0, out1, out2, out3, frame_valid,
        input  frame_ready
    );

    modport slave (
        input  out0, out1, out2, out3, frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/tdm_slot_decoder.sv
// One-hot slot decoder turning a slot index into capture enables.
// It is the receive-side dual of the transmit address mux.
module tdm_slot_decoder
    import tdm_pkg::*;
(
    input  logic [SLOT_IDX_W-1:0] idx,
    input  logic                  en,
    output logic [NUM_SLOTS-1:0]  sel
);

    // Raise exactly one enable for the addressed slot.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (en && idx == SLOT_IDX_W'(k)) begin
                sel[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demultiplexer.sv
// 4-channel TDM receiver with a one-frame output buffer.
// Optional build macro: TDM_PARITY_EN (5th parity slot, parity_err pulse).
module tdm_demultiplexer
    import tdm_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              sync,
    output logic              addr0,
    output logic              addr1,
    output logic              sync_err,
    output logic              overrun,
    tdm_demultiplexer_if.master frm
`ifdef TDM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    state_t                           state_q, state_d;
    logic [SLOT_IDX_W-1:0]            cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] cap_q, cap_d;
    logic [3:0][DATA_W-1:0]           buf_q, buf_d;
    logic                             fv_q, fv_d;
    logic                             serr_q, serr_d;
    logic                             ovr_q, ovr_d;
    logic                             perr_q, perr_d;

    logic                  take;
    logic [SLOT_IDX_W-1:0] wr_idx;
    logic [NUM_SLOTS-1:0]  wr_sel;
    logic                  complete;
    logic                  par_ok;
    logic                  load;

    // A sync always restarts at slot 0, even mid-frame.
    assign take   = din_valid & (sync | (state_q == RECV));
    assign wr_idx = sync ? '0 : cnt_q;

    tdm_slot_decoder u_dec (
        .idx (wr_idx),
        .en  (take),
        .sel (wr_sel)
    );

    // Slot sequencing, capture and frame-completion detection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        serr_d   = 1'b0;
        complete = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (wr_sel[k]) begin
                cap_d[k] = din;
            end
        end
        if (din_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (sync) begin
                        cnt_d   = SLOT_IDX_W'(1);
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (sync) begin
                        serr_d = 1'b1;
                        cnt_d  = SLOT_IDX_W'(1);
                    end else if (cnt_q == LAST_SLOT) begin
                        cnt_d    = '0;
                        state_d  = IDLE;
                        complete = 1'b1;
                    end else begin
                        cnt_d = cnt_q + SLOT_IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TDM_PARITY_EN
    assign par_ok = ((^cap_d[0]) ^ (^cap_d[1]) ^
                     (^cap_d[2]) ^ (^cap_d[3])) == din[0];
`else
    assign par_ok = 1'b1;
`endif

    // Output buffer: load when empty or drained this cycle, else drop.
    always_comb begin
        load   = complete & par_ok & (~fv_q | frm.frame_ready);
        buf_d  = buf_q;
        fv_d   = fv_q;
        ovr_d  = complete & par_ok & fv_q & ~frm.frame_ready;
        perr_d = complete & ~par_ok;
        if (load) begin
            buf_d = cap_d[3:0];
            fv_d  = 1'b1;
        end else if (fv_q & frm.frame_ready) begin
            fv_d = 1'b0;
        end
    end

    // State registers with asynchronous clear of all frame data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            buf_q   <= '0;
            fv_q    <= 1'b0;
            serr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            buf_q   <= buf_d;
            fv_q    <= fv_d;
            serr_q  <= serr_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign addr0           = cnt_q[0];
    assign addr1           = cnt_q[1];
    assign sync_err        = serr_q;
    assign overrun         = ovr_q;
    assign frm.out0        = buf_q[0];
    assign frm.out1        = buf_q[1];
    assign frm.out2        = buf_q[2];
    assign frm.out3        = buf_q[3];
    assign frm.frame_valid = fv_q;
`ifdef TDM_PARITY_EN
    assign parity_err      = perr_q;
`else
    logic unused_perr;
    assign unused_perr     = perr_q;
`endif

endmodule

// File: doc/tdm_demultiplexer.md
Name: tdm_demultiplexer

Overview:
- Receive side of the 4-channel time-division link; the transmit side is the 4:1 address-selected multiplexer.
- Accepts one slot per valid cycle on a shared data line and steers it to one of four channel registers using an internal 2-bit slot address (addr1:addr0).
- When a frame is complete, presents all four channels together to a consumer through a valid/ready handshake. A one-frame output buffer lets reception continue while the consumer stalls.

Parameters:
- DATA_W, 1, width of each slot and of each channel output.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  slot data from the link.
- din_valid  in  1  din carries a slot this cycle.
- sync  in  1  marks the slot-0 cycle; only sampled when din_valid=1.
- addr0  out  1  LSB of the next slot index to be filled.
- addr1  out  1  MSB of the next slot index to be filled.
- out0..out3  out  DATA_W each  buffered channel 0..3 data.
- frame_valid  out  1  out0..out3 hold a complete frame.
- frame_ready  in  1  consumer accepts the frame.
- sync_err  out  1  one-cycle pulse: sync arrived mid-frame.
- overrun  out  1  one-cycle pulse: completed frame dropped because the buffer was full.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, slot counter=0, capture regs=0.
  - out0..out3=0, frame_valid=0, sync_err=0, overrun=0, addr1:addr0=00.
  - Reset asserted mid-frame discards the partial frame and any buffered frame.
- States: IDLE, RECV.
- IDLE:
  - din_valid&sync: din -> capture[0]; counter=1; go to RECV.
  - Anything else is ignored, including din_valid with no sync.
- RECV, din_valid&!sync: din -> capture[counter]; counter++.
  - Slot 3 captured: counter=0, go to IDLE, and the frame completes.
- RECV, din_valid&sync: sync_err=1 for the next cycle. The partial frame is discarded; din -> capture[0]; counter=1; stay in RECV.
- RECV, din_valid=0: hold; there is no timeout.
- addr1:addr0 always equals the counter, i.e. the next slot index.
- Frame completion, registered; frame_valid asserts the cycle after slot 3 is sampled (latency 1):
  - Buffer empty (frame_valid=0), or frame_valid&frame_ready in the same cycle: load the buffer; frame_valid=1.
  - frame_valid&!frame_ready: the new frame is dropped, the buffer is unchanged, overrun=1 for one cycle.
- Handshake:
  - frame_valid&frame_ready with no completion that cycle: frame_valid=0 next cycle.
  - out0..out3 hold their last value after acceptance; they are not cleared.
  - out0..out3 stay stable while frame_valid=1 and frame_ready=0.
- Slot k always maps to outk. This is the exact inverse of the transmit mux select: addr1:addr0=01 selects channel 1.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - Each frame has a 5th slot (index 4). Its bit 0 is the even parity of the 4*DATA_W data bits; other bits are ignored.
  - The counter is 3 bits; addr1:addr0 show the low bits.
  - Completion occurs on slot 4. On a parity mismatch the frame is dropped and the extra output parity_err (1 bit) pulses for one cycle. A parity error takes precedence over overrun.
- Undefined: 4-slot frames, no parity_err port, behaviour as above.

Decomposition:
- Package tdm_pkg:
  - State enum {IDLE, RECV}.
  - NUM_SLOTS (4, or 5 under TDM_PARITY_EN).
  - SLOT_IDX_W.
- Sub-module tdm_slot_decoder: combinational 2-to-4 one-hot decoder, from counter plus din_valid to capture enables. It is the structural dual of the transmit mux.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> out0..out3=0, frame_valid=0, addr=00, sync_err=0, overrun=0.
- Basic frame: DATA_W=1, frame_ready=1. Drive din 1(sync),0,1,1 on four consecutive valid cycles -> addr steps 01,10,11,00; the next cycle shows out0..out3=1,0,1,1 and a one-cycle frame_valid pulse.
- Gapped input: same frame with din_valid=0 for 3 cycles between slots -> identical outputs; frame_valid asserts 1 cycle after the last slot.
- Backpressure: frame_ready=0, frame A=1,1,0,0 then frame B=0,1,0,1 -> outputs stay A, overrun pulses once. Then frame_ready=1 for 1 cycle -> frame_valid drops.
- Mid-frame sync: 2 slots, then sync with din=0, then 1,1,0 -> sync_err pulses once; the frame delivered is 0,1,1,0.
- Reset mid-frame: reset_n low after slot 1 and released, then a full frame 1,1,1,1 -> only 1,1,1,1 is delivered, with no stale data.
